inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//  Decoupling queue between the fetch stage (PC register + I-cache return) and decode.
//  - Accepts up to two sequential instructions per cycle from fetch.
//  - Presents the two oldest entries to the dual-issue decoder.
//  - Drives the fetch stage's PC hold when it cannot take two more entries.
//  - Emptied in one cycle on a jump or exception flush.
// PARAMETERS
//  DEPTH  8  number of entries; power of two, >= 4
// PORTS
//  clk            in   1   single clock domain
//  rst_n          in   1   one clock; reset is asynchronous and active-low
//  flush          in   1   exception flush OR redirect jump; empties the queue
//  push_valid1    in   1   fetch slot 1 valid
//  push_valid2    in   1   fetch slot 2 valid; only legal with push_valid1
//  push_pc        in   32  PC of slot 1; slot 2 PC = push_pc + 4
//  push_inst1     in   32  instruction word, slot 1
//  push_inst2     in   32  instruction word, slot 2
//  push_addr_err  in   1   fetch address error on slot 1; slot 2 never carries one
//  full           out  1   fewer than 2 free entries; feeds fetch PC hold
//  pop_cnt        in   2   entries the decoder consumes this cycle (0,1,2)
//  out1_valid     out  1   oldest entry present
//  out1_pc        out  32  PC of oldest entry
//  out1_inst      out  32  instruction word of oldest entry
//  out1_addr_err  out  1   address-error flag of oldest entry
//  out2_valid     out  1   second-oldest entry present
//  out2_pc        out  32  PC of second-oldest entry
//  out2_inst      out  32  instruction word of second-oldest entry
//  count          out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//  - Storage: circular buffer of DEPTH entries {pc, inst, addr_err}.
//    head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is a separate register.
//  - Reset (async, rst_n=0): head=tail=count=0.
//    All outX_valid=0; outX_pc/inst/addr_err=0; full=0.
//  - Outputs are combinational from head, head+1 and count.
//    out1_valid=(count>=1), out2_valid=(count>=2).
//    An invalid slot drives pc=0, inst=0 (NOP), addr_err=0.
//  - full = (DEPTH - count) < 2, from the registered count only. No dependency on pop_cnt (no comb path to fetch).
//  - Push, when push_valid1 && !full && !flush:
//    - write slot 1 at tail.
//    - if push_valid2, also write slot 2 at tail+1 with pc = push_pc + 4, addr_err = 0.
//    - tail advances 1 or 2.
//    Push while full is dropped; fetch must be holding.
//  - Pop, when !flush: effective pop = min(pop_cnt, count).
//    - pop_cnt > count is a protocol error; bench asserts on it, RTL clamps.
//    - pop_cnt = 3 is treated as 2.
//    - head advances by the effective pop.
//  - Same-cycle push and pop are both applied.
//    count_next = count + pushed - popped (no overflow, since full already guarantees 2 free).
//  - Latency: an entry pushed in cycle N is visible on out1/out2 in cycle N+1. There is no bypass from push to out.
//  - flush=1: next cycle head=tail=count=0. Same-cycle push and pop are ignored.
//    The first post-flush push (cycle N+1) appears at N+2.
//  - Wrap-around: pointers roll DEPTH-1 -> 0.
//    Slot 2 written at index 0 when tail=DEPTH-1 is legal.
//  - push_valid2 without push_valid1 is illegal; treated as no push; bench asserts.
// STRUCTURE
//  - Shared package (cpu_defs):
//    - FetchEntry_t struct {InstAddr_t pc; Inst_t inst; Bit_t addr_err;}
//    - FETCH_QUEUE_DEPTH constant.
//  - Single module; no sub-module. Entry array plus pointer/count logic is sufficient.
// TESTING
//  1. Reset mid-operation: count=5, drop rst_n asynchronously.
//     -> same-edge-free: count=0, out1_valid=0, out1_inst=0, full=0.
//  2. Dual push pc=0xBFC00000, inst 0x11,0x22, pop_cnt=0.
//     -> next cycle: out1 pc 0xBFC00000/0x11, out2 pc 0xBFC00004/0x22, count=2.
//  3. Fill DEPTH=8 with dual pushes, no pops.
//     -> full=1 at count=7 and count=8.
//     -> further push while full dropped; count stays; data unchanged.
//  4. Wrap: head=tail=7, dual push A,B and pop_cnt=0.
//     -> A at index 7, B at index 0.
//     -> pop 2 returns A then B; head=1.
//  5. flush with push_valid1=1 and pop_cnt=2 in the same cycle.
//     -> next cycle count=0, both out valids 0.
//     -> pushed entry never appears.
//  6. count=1, push 2 and pop_cnt=1 in the same cycle.
//     -> count=2; out1 = first pushed entry.
//     -> addr_err on slot 1 propagates to out1_addr_err=1.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU front-end types: fetch queue entry layout, depth and pop-request helper.
package cpu_defs;

  localparam int FETCH_QUEUE_DEPTH = 8;

  typedef logic [31:0] InstAddr_t;
  typedef logic [31:0] Inst_t;
  typedef logic        Bit_t;

  typedef struct packed {
    InstAddr_t pc;
    Inst_t     inst;
    Bit_t      addr_err;
  } FetchEntry_t;

  // The decoder is only two wide, so a request of 3 is folded down to 2.
  function automatic logic [1:0] pop_request(input logic [1:0] pop_cnt);
    return (pop_cnt == 2'd3) ? 2'd2 : pop_cnt;
  endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode decoupling queue: two-wide push from fetch, two-wide pop to decode,
// single-cycle flush on redirect or exception.
module inst_fetch_queue
  import cpu_defs::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push_valid1,
  input  logic                     push_valid2,
  input  logic [31:0]              push_pc,
  input  logic [31:0]              push_inst1,
  input  logic [31:0]              push_inst2,
  input  logic                     push_addr_err,
  output logic                     full,
  input  logic [1:0]               pop_cnt,
  output logic                     out1_valid,
  output logic [31:0]              out1_pc,
  output logic [31:0]              out1_inst,
  output logic                     out1_addr_err,
  output logic                     out2_valid,
  output logic [31:0]              out2_pc,
  output logic [31:0]              out2_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  FetchEntry_t mem [DEPTH];
  ptr_t        head;
  ptr_t        tail;
  cnt_t        count_q;

  logic        push_en;
  cnt_t        push_num;
  cnt_t        pop_num;
  logic [1:0]  pop_req;
  ptr_t        head_next1;
  ptr_t        tail_next1;

  // Full looks only at the registered occupancy so fetch never sees a path from pop_cnt.
  assign full  = (cnt_t'(DEPTH) - count_q) < cnt_t'(2);
  assign count = count_q;

  always_comb begin
    push_en  = push_valid1 && !full && !flush;
    push_num = '0;
    if (push_en) begin
      push_num = push_valid2 ? cnt_t'(2) : cnt_t'(1);
    end
    pop_req = pop_request(pop_cnt);
    pop_num = '0;
    if (!flush) begin
      pop_num = (cnt_t'(pop_req) > count_q) ? count_q : cnt_t'(pop_req);
    end
    head_next1 = head + ptr_t'(1);
    tail_next1 = tail + ptr_t'(1);
  end

  // Slot 2 always sits one past slot 1; its address error is never reported.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[tail] <= '{pc: push_pc, inst: push_inst1, addr_err: push_addr_err};
      if (push_valid2) begin
        mem[tail_next1] <= '{pc: push_pc + 32'd4, inst: push_inst2, addr_err: 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + ptr_t'(pop_num);
      tail    <= tail + ptr_t'(push_num);
      count_q <= count_q + push_num - pop_num;
    end
  end

  // Empty decode slots present a zero NOP so downstream never sees stale entries.
  always_comb begin
    out1_valid    = count_q >= cnt_t'(1);
    out2_valid    = count_q >= cnt_t'(2);
    out1_pc       = '0;
    out1_inst     = '0;
    out1_addr_err = 1'b0;
    out2_pc       = '0;
    out2_inst     = '0;
    if (out1_valid) begin
      out1_pc       = mem[head].pc;
      out1_inst     = mem[head].inst;
      out1_addr_err = mem[head].addr_err;
    end
    if (out2_valid) begin
      out2_pc   = mem[head_next1].pc;
      out2_inst = mem[head_next1].inst;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: fixed vector table, directed corner sequences,
// then random traffic compared against a queue-based reference model.
module tb_inst_fetch_queue;
  import cpu_defs::*;

  localparam int DEPTH = FETCH_QUEUE_DEPTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          push_valid1;
  logic          push_valid2;
  logic [31:0]   push_pc;
  logic [31:0]   push_inst1;
  logic [31:0]   push_inst2;
  logic          push_addr_err;
  logic          full;
  logic [1:0]    pop_cnt;
  logic          out1_valid;
  logic [31:0]   out1_pc;
  logic [31:0]   out1_inst;
  logic          out1_addr_err;
  logic          out2_valid;
  logic [31:0]   out2_pc;
  logic [31:0]   out2_inst;
  logic [CW-1:0] count;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push_valid1(push_valid1), .push_valid2(push_valid2), .push_pc(push_pc),
    .push_inst1(push_inst1), .push_inst2(push_inst2), .push_addr_err(push_addr_err),
    .full(full), .pop_cnt(pop_cnt),
    .out1_valid(out1_valid), .out1_pc(out1_pc), .out1_inst(out1_inst),
    .out1_addr_err(out1_addr_err),
    .out2_valid(out2_valid), .out2_pc(out2_pc), .out2_inst(out2_inst),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } model_entry_t;

  typedef struct {
    logic        f, p1, p2;
    logic [31:0] pc, i1, i2;
    logic        e;
    logic [1:0]  pop;
    int          exp_count;
    logic        exp_full, exp_v1;
    logic [31:0] exp_pc1, exp_inst1;
    logic        exp_err1, exp_v2;
    logic [31:0] exp_pc2, exp_inst2;
  } vec_t;

  model_entry_t model_q[$];
  vec_t         vecs[15];
  int           vec_cnt = 0;
  int           err_cnt = 0;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Protocol monitor: decoder must never ask for more than is present, slot 2 needs slot 1.
  always @(posedge clk) begin
    if (rst_n && !flush && (32'(pop_cnt) > 32'(count))) begin
      err_cnt++;
      $display("[TB] FAIL protocol pop_cnt: got %0d, count only %0d", pop_cnt, count);
    end
    if (rst_n && push_valid2 && !push_valid1) begin
      err_cnt++;
      $display("[TB] FAIL protocol push_valid2: got 1 without push_valid1, expected 0");
    end
  end

  task automatic apply_stimulus(input logic f, input logic p1, input logic p2,
                                input logic [31:0] pc, input logic [31:0] i1,
                                input logic [31:0] i2, input logic e, input logic [1:0] pop);
    flush = f; push_valid1 = p1; push_valid2 = p2; push_pc = pc;
    push_inst1 = i1; push_inst2 = i2; push_addr_err = e; pop_cnt = pop;
  endtask

  // Reference: a FIFO of entries; full judged on pre-cycle occupancy, pop clamped to contents.
  task automatic model_update(input logic f, input logic p1, input logic p2,
                              input logic [31:0] pc, input logic [31:0] i1,
                              input logic [31:0] i2, input logic e, input logic [1:0] pop);
    int  n;
    int  take;
    bit  was_full;
    n = model_q.size();
    if (f) begin
      model_q.delete();
      return;
    end
    was_full = (DEPTH - n) < 2;
    take = (pop == 2'd3) ? 2 : int'(pop);
    if (take > n) take = n;
    repeat (take) void'(model_q.pop_front());
    if (p1 && !was_full) begin
      model_q.push_back('{pc: pc, inst: i1, err: e});
      if (p2) model_q.push_back('{pc: pc + 32'd4, inst: i2, err: 1'b0});
    end
  endtask

  task automatic check_output(input string tag);
    int n;
    n = model_q.size();
    check_val({tag, " count"}, 32'(count), 32'(n));
    check_val({tag, " full"}, 32'(full), ((DEPTH - n) < 2) ? 32'd1 : 32'd0);
    check_val({tag, " out1_valid"}, 32'(out1_valid), (n >= 1) ? 32'd1 : 32'd0);
    check_val({tag, " out1_pc"}, out1_pc, (n >= 1) ? model_q[0].pc : 32'd0);
    check_val({tag, " out1_inst"}, out1_inst, (n >= 1) ? model_q[0].inst : 32'd0);
    check_val({tag, " out1_addr_err"}, 32'(out1_addr_err), (n >= 1) ? 32'(model_q[0].err) : 32'd0);
    check_val({tag, " out2_valid"}, 32'(out2_valid), (n >= 2) ? 32'd1 : 32'd0);
    check_val({tag, " out2_pc"}, out2_pc, (n >= 2) ? model_q[1].pc : 32'd0);
    check_val({tag, " out2_inst"}, out2_inst, (n >= 2) ? model_q[1].inst : 32'd0);
  endtask

  task automatic step(input string tag, input logic f, input logic p1, input logic p2,
                      input logic [31:0] pc, input logic [31:0] i1, input logic [31:0] i2,
                      input logic e, input logic [1:0] pop);
    apply_stimulus(f, p1, p2, pc, i1, i2, e, pop);
    @(posedge clk);
    #1;
    model_update(f, p1, p2, pc, i1, i2, e, pop);
    check_output(tag);
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 2'd0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_output("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    // pc, inst words and expected decode-side view after each cycle, starting from empty
    vecs[0]  = '{0,1,1,32'hBFC00000,32'h11,32'h22,0,0, 2,0,1,32'hBFC00000,32'h11,0,1,32'hBFC00004,32'h22};
    vecs[1]  = '{0,1,1,32'hBFC00008,32'h33,32'h44,0,0, 4,0,1,32'hBFC00000,32'h11,0,1,32'hBFC00004,32'h22};
    vecs[2]  = '{0,1,1,32'hBFC00010,32'h55,32'h66,0,0, 6,0,1,32'hBFC00000,32'h11,0,1,32'hBFC00004,32'h22};
    vecs[3]  = '{0,1,0,32'hBFC00018,32'h77,32'h00,0,0, 7,1,1,32'hBFC00000,32'h11,0,1,32'hBFC00004,32'h22};
    vecs[4]  = '{0,1,1,32'hDEAD0000,32'hEE,32'hFF,1,0, 7,1,1,32'hBFC00000,32'h11,0,1,32'hBFC00004,32'h22};
    vecs[5]  = '{0,0,0,32'h0,32'h0,32'h0,0,1,           6,0,1,32'hBFC00004,32'h22,0,1,32'hBFC00008,32'h33};
    vecs[6]  = '{0,1,1,32'hBFC00020,32'h88,32'h99,0,0, 8,1,1,32'hBFC00004,32'h22,0,1,32'hBFC00008,32'h33};
    vecs[7]  = '{0,1,1,32'hDEAD0100,32'hEE,32'hFF,1,0, 8,1,1,32'hBFC00004,32'h22,0,1,32'hBFC00008,32'h33};
    vecs[8]  = '{0,0,0,32'h0,32'h0,32'h0,0,3,           6,0,1,32'hBFC0000C,32'h44,0,1,32'hBFC00010,32'h55};
    vecs[9]  = '{0,0,0,32'h0,32'h0,32'h0,0,2,           4,0,1,32'hBFC00014,32'h66,0,1,32'hBFC00018,32'h77};
    vecs[10] = '{0,0,0,32'h0,32'h0,32'h0,0,2,           2,0,1,32'hBFC00020,32'h88,0,1,32'hBFC00024,32'h99};
    vecs[11] = '{0,0,0,32'h0,32'h0,32'h0,0,2,           0,0,0,32'h0,32'h0,0,0,32'h0,32'h0};
    vecs[12] = '{0,1,0,32'h00000100,32'hA1,32'h00,0,0, 1,0,1,32'h100,32'hA1,0,0,32'h0,32'h0};
    vecs[13] = '{0,1,1,32'h00000200,32'hB1,32'hB2,1,1, 2,0,1,32'h200,32'hB1,1,1,32'h204,32'hB2};
    vecs[14] = '{0,0,0,32'h0,32'h0,32'h0,0,2,           0,0,0,32'h0,32'h0,0,0,32'h0,32'h0};

    rst_n = 1'b0;
    idle();
    do_reset();

    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i].f, vecs[i].p1, vecs[i].p2, vecs[i].pc, vecs[i].i1,
                     vecs[i].i2, vecs[i].e, vecs[i].pop);
      @(posedge clk);
      #1;
      check_val($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
      check_val($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].exp_full));
      check_val($sformatf("vec%0d out1_valid", i), 32'(out1_valid), 32'(vecs[i].exp_v1));
      check_val($sformatf("vec%0d out1_pc", i), out1_pc, vecs[i].exp_pc1);
      check_val($sformatf("vec%0d out1_inst", i), out1_inst, vecs[i].exp_inst1);
      check_val($sformatf("vec%0d out1_addr_err", i), 32'(out1_addr_err), 32'(vecs[i].exp_err1));
      check_val($sformatf("vec%0d out2_valid", i), 32'(out2_valid), 32'(vecs[i].exp_v2));
      check_val($sformatf("vec%0d out2_pc", i), out2_pc, vecs[i].exp_pc2);
      check_val($sformatf("vec%0d out2_inst", i), out2_inst, vecs[i].exp_inst2);
    end

    // Asynchronous reset dropped mid-cycle with five entries held
    do_reset();
    step("rst_mid", 0, 1, 1, 32'h1000, 32'hC1, 32'hC2, 0, 0);
    step("rst_mid", 0, 1, 1, 32'h1008, 32'hC3, 32'hC4, 0, 0);
    step("rst_mid", 0, 1, 0, 32'h1010, 32'hC5, 32'h00, 1, 0);
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    check_output("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Walk pointers to 7, then a dual push straddles the wrap point
    step("wrap_fill", 0, 1, 0, 32'h2000, 32'hD0, 32'h0, 0, 0);
    for (int i = 1; i < 7; i++) begin
      step("wrap_walk", 0, 1, 0, 32'h2000 + 32'(i * 4), 32'hD0 + 32'(i), 32'h0, 0, 1);
    end
    step("wrap_drain", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1);
    step("wrap_push", 0, 1, 1, 32'h3000, 32'hAAAA0001, 32'hBBBB0002, 1, 0);
    step("wrap_pop", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 2);
    step("wrap_after", 0, 1, 0, 32'h4000, 32'hCCCC0003, 32'h0, 0, 0);

    // Flush wins over a same-cycle push and pop
    step("flush_fill", 0, 1, 1, 32'h5000, 32'hE1, 32'hE2, 0, 0);
    step("flush", 1, 1, 1, 32'h6000, 32'hF1, 32'hF2, 0, 2);
    step("flush_after", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    step("flush_push", 0, 1, 0, 32'h7000, 32'h71, 32'h0, 0, 0);
    step("flush_pop", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1);

    // Randomised traffic, legal protocol only
    for (int c = 0; c < 3000; c++) begin
      logic        f, p1, p2, e;
      logic [1:0]  pop;
      int          n, maxp;
      n    = model_q.size();
      maxp = (n > 3) ? 3 : n;
      f    = ($urandom_range(0, 31) == 0);
      p1   = ($urandom_range(0, 3) != 0);
      p2   = p1 && ($urandom_range(0, 1) == 1);
      e    = ($urandom_range(0, 7) == 0);
      pop  = 2'($urandom_range(0, maxp));
      step("random", f, p1, p2, {$urandom_range(0, 32'h3FFFFFFF), 2'b00}, $urandom, $urandom, e, pop);
    end

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
